// File: rtl/ram_sync_init.sv
// ram_sync_init: single-port synchronous RAM that fills itself with INIT_VAL
// after every reset, then serves reads and writes with a 1- or 2-cycle
// registered read path and selectable same-address read-during-write behaviour.
module ram_sync_init #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 RD_LAT   = 1,
  parameter int                 RDW_MODE = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              we,
  input  logic              rd,
  output logic [DATA_W-1:0] dataOut,
  output logic              rd_valid,
  output logic              busy,
  output logic              drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] init_cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] data_in_p1;
  logic              vld_in_p1;

  assign busy  = (state == INIT);
  assign rd_ok = rd && (state == READY);

  // Write-first forwards the incoming word; the port has one shared address,
  // so any simultaneous write necessarily targets the word being read.
  assign rd_word = (RDW_MODE == 1 && we) ? dataIn : mem[address];

  // State and init counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Next-state logic: sweep every word once, leave INIT on the last one
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == {ADDR_W{1'b1}}) begin
          state_nxt = READY;
        end
      end
      READY: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Memory array: init sequencer owns the port in INIT, user writes in READY
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[init_cnt] <= INIT_VAL;
      end else if (we) begin
        mem[address] <= dataIn;
      end
    end
  end

  // Rejected-access pulse while the init sequence owns the memory
  always_ff @(posedge clock) begin
    if (reset) begin
      drop <= 1'b0;
    end else begin
      drop <= (state == INIT) && (we || rd);
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] data_p0;
      logic              vld_p0;

      // ---- stage p0: array read ----
      // Valid tracks the read through the pipe and is flushed by reset
      always_ff @(posedge clock) begin
        if (reset) begin
          vld_p0 <= 1'b0;
        end else begin
          vld_p0 <= rd_ok;
        end
      end

      // Captured word; qualified by vld_p0 so it needs no reset
      always_ff @(posedge clock) begin
        if (rd_ok) begin
          data_p0 <= rd_word;
        end
      end

      assign vld_in_p1  = vld_p0;
      assign data_in_p1 = data_p0;
    end else begin : g_lat1
      assign vld_in_p1  = rd_ok;
      assign data_in_p1 = rd_word;
    end
  endgenerate

  // ---- stage p1: output register ----
  // Output holds its value between reads and clears on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_in_p1;
      if (vld_in_p1) begin
        data_p1 <= data_in_p1;
      end
    end
  end

  assign dataOut  = data_p1;
  assign rd_valid = vld_p1;

endmodule

// File: tb/tb_ram_sync_init.sv
// tb_ram_sync_init: directed bench driving three ram_sync_init variants from
// one shared stimulus stream:
//   u0: RD_LAT=1, read-first,  INIT_VAL=00
//   u1: RD_LAT=2, write-first, INIT_VAL=00
//   u2: RD_LAT=1, read-first,  INIT_VAL=5A
module tb_ram_sync_init;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] address = '0;
  logic [7:0] dataIn = '0;
  logic       we = 1'b0;
  logic       rd = 1'b0;

  logic [7:0] do0, do1, do2;
  logic       rv0, rv1, rv2;
  logic       busy0, busy1, busy2;
  logic       drop0, drop1, drop2;

  int n_chk = 0;
  int n_bad = 0;
  int edges;

  always #5 clock = ~clock;

  ram_sync_init #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(8'h00)) u0 (
    .clock(clock), .reset(reset), .address(address), .dataIn(dataIn), .we(we), .rd(rd),
    .dataOut(do0), .rd_valid(rv0), .busy(busy0), .drop(drop0));

  ram_sync_init #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(8'h00)) u1 (
    .clock(clock), .reset(reset), .address(address), .dataIn(dataIn), .we(we), .rd(rd),
    .dataOut(do1), .rd_valid(rv1), .busy(busy1), .drop(drop1));

  ram_sync_init #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(8'h5A)) u2 (
    .clock(clock), .reset(reset), .address(address), .dataIn(dataIn), .we(we), .rd(rd),
    .dataOut(do2), .rd_valid(rv2), .busy(busy2), .drop(drop2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // read one address: LAT1 units answer after the rd edge, LAT2 one edge later
  task automatic rd_chk(input logic [3:0] a, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2);
    address = a; rd = 1'b1; we = 1'b0;
    tick();
    check($sformatf("rv0@%0d", a), rv0, 1);
    check($sformatf("do0@%0d", a), do0, e0);
    check($sformatf("rv2@%0d", a), rv2, 1);
    check($sformatf("do2@%0d", a), do2, e2);
    check($sformatf("rv1_early@%0d", a), rv1, 0);
    rd = 1'b0;
    tick();
    check($sformatf("rv1@%0d", a), rv1, 1);
    check($sformatf("do1@%0d", a), do1, e1);
    check($sformatf("rv0_off@%0d", a), rv0, 0);
    check($sformatf("do0_hold@%0d", a), do0, e0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; dataIn = d; we = 1'b1; rd = 1'b0;
    tick();
    we = 1'b0;
  endtask

  // count edges until busy drops, bounded
  task automatic count_busy(input string tag, input int start);
    edges = start;
    while (busy0 && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_busy_edges"}, edges, 16);
    check({tag, "_busy1"}, busy1, 0);
    check({tag, "_busy2"}, busy2, 0);
  endtask

  initial begin
    // reset for two cycles
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", busy0, 1);
    check("rst_rv0", rv0, 0);
    check("rst_do0", do0, 0);
    check("rst_rv1", rv1, 0);
    check("rst_do1", do1, 0);
    check("rst_drop0", drop0, 0);

    // release with an illegal access on the first init edge
    reset = 1'b0; we = 1'b1; rd = 1'b1; address = 4'd5; dataIn = 8'h55;
    tick();
    check("busy_drop0", drop0, 1);
    check("busy_drop1", drop1, 1);
    check("busy_drop2", drop2, 1);
    check("busy_rv0", rv0, 0);
    check("busy_do0", do0, 0);
    check("busy_b", busy0, 1);
    we = 1'b0; rd = 1'b0;
    tick();
    check("drop_pulse", drop0, 0);
    check("busy_rv1", rv1, 0);
    count_busy("init", 2);

    // every word holds the init value, including the word hit while busy
    for (int i = 0; i < 16; i++) rd_chk(4'(i), 8'h00, 8'h00, 8'h5A);

    // write then read
    wr(4'd0, 8'hF0);
    wr(4'd1, 8'h0F);
    rd_chk(4'd0, 8'hF0, 8'hF0, 8'hF0);
    rd_chk(4'd1, 8'h0F, 8'h0F, 8'h0F);

    // read-during-write at the same address
    wr(4'd3, 8'h02);
    address = 4'd3; dataIn = 8'hAA; we = 1'b1; rd = 1'b1;
    tick();
    check("rdw_rv0", rv0, 1);
    check("rdw_old0", do0, 8'h02);
    check("rdw_old2", do2, 8'h02);
    we = 1'b0; rd = 1'b0;
    tick();
    check("rdw_rv1", rv1, 1);
    check("rdw_new1", do1, 8'hAA);
    rd_chk(4'd3, 8'hAA, 8'hAA, 8'hAA);

    // back-to-back reads through the 2-cycle pipe
    address = 4'd0; rd = 1'b1;
    tick();
    check("b2b_do0_a", do0, 8'hF0);
    address = 4'd1;
    tick();
    check("b2b_do0_b", do0, 8'h0F);
    check("b2b_rv1_a", rv1, 1);
    check("b2b_do1_a", do1, 8'hF0);
    rd = 1'b0;
    tick();
    check("b2b_rv1_b", rv1, 1);
    check("b2b_do1_b", do1, 8'h0F);
    check("b2b_rv0_off", rv0, 0);
    tick();
    check("b2b_rv1_off", rv1, 0);

    // reset one edge after a read: the in-flight LAT2 read is discarded
    address = 4'd0; rd = 1'b1;
    tick();
    check("mr_rv0", rv0, 1);
    reset = 1'b1; rd = 1'b0;
    tick();
    check("mr_rv1", rv1, 0);
    check("mr_do1", do1, 0);
    check("mr_do0", do0, 0);
    reset = 1'b0;
    tick();
    check("mr_rv1_after", rv1, 0);
    check("mr_do1_after", do1, 0);

    // that was init edge 1; reset again after 7 init edges
    for (int i = 0; i < 6; i++) tick();
    check("mi_busy_pre", busy0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy("midinit", 0);
    for (int i = 0; i < 16; i++) rd_chk(4'(i), 8'h00, 8'h00, 8'h5A);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
